// File: rtl/axim_bridge.sv
// axim_bridge: turns single load/store requests from the LSU into AXI4-Lite
// master transactions, one outstanding at a time, and hands completion status
// and read data back to the LSU with a one-cycle ready pulse.
module axim_bridge #(
   parameter logic [2:0]  PROT     = 3'b000,
   parameter logic [31:0] ERR_RDAT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hs_ls4axim_val,
   output logic        hs_axim4ls_rdy,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_wdat,
   input  logic [3:0]  i_axim_wen,
   output logic [31:0] o_rdat,
   output logic        o_err,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic [31:0] o_awaddr,
   output logic [2:0]  o_awprot,
   output logic        o_wvalid,
   input  logic        i_wready,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   input  logic        i_bvalid,
   output logic        o_bready,
   input  logic [1:0]  i_bresp,
   output logic        o_arvalid,
   input  logic        i_arready,
   output logic [31:0] o_araddr,
   output logic [2:0]  o_arprot,
   input  logic        i_rvalid,
   output logic        o_rready,
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_rresp
);

   typedef enum logic [2:0] {
      IDLE,
      WREQ,
      WRESP,
      RREQ,
      RRESP,
      DONE
   } state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic        r_awPend;
   logic        r_wPend;
   logic [31:0] r_adr;
   logic [31:0] r_wdat;
   logic [3:0]  r_wen;
   logic [31:0] r_rdat;
   logic        r_err;

   logic        w_accept;
   logic        w_awHs;
   logic        w_wHs;
   logic        w_awLeft;
   logic        w_wLeft;
   logic        w_unusedResp;

   // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
   assign w_unusedResp = ^{i_bresp[0], i_rresp[0]};

   // A new request is only taken in IDLE; in DONE the LSU still shows the old one.
   assign w_accept = (r_state == IDLE) && hs_ls4axim_val;
   assign w_awHs   = o_awvalid && i_awready;
   assign w_wHs    = o_wvalid && i_wready;
   assign w_awLeft = r_awPend && !w_awHs;
   assign w_wLeft  = r_wPend && !w_wHs;

   // All AXI payloads come straight from the captured request registers.
   assign o_awaddr = r_adr;
   assign o_araddr = r_adr;
   assign o_wdata  = r_wdat;
   assign o_wstrb  = r_wen;
   assign o_awprot = PROT;
   assign o_arprot = PROT;
   assign o_rdat   = r_rdat;
   assign o_err    = r_err;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: each wait on a ready/valid simply holds the current state.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (hs_ls4axim_val) begin
               w_nextState = (|i_axim_wen) ? WREQ : RREQ;
            end
         end
         WREQ: begin
            if (!w_awLeft && !w_wLeft) begin
               w_nextState = WRESP;
            end
         end
         WRESP: begin
            if (i_bvalid) begin
               w_nextState = DONE;
            end
         end
         RREQ: begin
            if (i_arready) begin
               w_nextState = RRESP;
            end
         end
         RRESP: begin
            if (i_rvalid) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output decode: valids and readies are pure functions of registered state.
   always_comb begin
      o_awvalid      = 1'b0;
      o_wvalid       = 1'b0;
      o_bready       = 1'b0;
      o_arvalid      = 1'b0;
      o_rready       = 1'b0;
      hs_axim4ls_rdy = 1'b0;
      case (r_state)
         WREQ: begin
            o_awvalid = r_awPend;
            o_wvalid  = r_wPend;
         end
         WRESP: begin
            o_bready = 1'b1;
         end
         RREQ: begin
            o_arvalid = 1'b1;
         end
         RRESP: begin
            o_rready = 1'b1;
         end
         DONE: begin
            hs_axim4ls_rdy = 1'b1;
         end
         default: begin
            o_awvalid = 1'b0;
         end
      endcase
   end

   // Request capture, independent AW/W pending flags, and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_awPend <= 1'b0;
         r_wPend  <= 1'b0;
         r_adr    <= '0;
         r_wdat   <= '0;
         r_wen    <= '0;
         r_rdat   <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_adr    <= i_adr;
            r_wdat   <= i_wdat;
            r_wen    <= i_axim_wen;
            r_awPend <= |i_axim_wen;
            r_wPend  <= |i_axim_wen;
         end else begin
            if (w_awHs) begin
               r_awPend <= 1'b0;
            end
            if (w_wHs) begin
               r_wPend <= 1'b0;
            end
         end
         if ((r_state == WRESP) && i_bvalid) begin
            r_err  <= i_bresp[1];
            r_rdat <= '0;
         end
         if ((r_state == RRESP) && i_rvalid) begin
            r_err  <= i_rresp[1];
            r_rdat <= i_rresp[1] ? ERR_RDAT : i_rdata;
         end
      end
   end

endmodule

// File: tb/tb_axim_bridge.sv
// tb_axim_bridge: drives LSU requests into axim_bridge against a behavioural
// AXI4-Lite slave with configurable delays and responses.
`timescale 1ns/1ps
module tb_axim_bridge;

   localparam logic [31:0] ERR_RDAT = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        hs_ls4axim_val;
   logic        hs_axim4ls_rdy;
   logic [31:0] i_adr;
   logic [31:0] i_wdat;
   logic [3:0]  i_axim_wen;
   logic [31:0] o_rdat;
   logic        o_err;
   logic        o_awvalid;
   logic        i_awready;
   logic [31:0] o_awaddr;
   logic [2:0]  o_awprot;
   logic        o_wvalid;
   logic        i_wready;
   logic [31:0] o_wdata;
   logic [3:0]  o_wstrb;
   logic        i_bvalid;
   logic        o_bready;
   logic [1:0]  i_bresp;
   logic        o_arvalid;
   logic        i_arready;
   logic [31:0] o_araddr;
   logic [2:0]  o_arprot;
   logic        i_rvalid;
   logic        o_rready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;

   axim_bridge #(
      .PROT     (3'b000),
      .ERR_RDAT (ERR_RDAT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hs_ls4axim_val (hs_ls4axim_val),
      .hs_axim4ls_rdy (hs_axim4ls_rdy),
      .i_adr          (i_adr),
      .i_wdat         (i_wdat),
      .i_axim_wen     (i_axim_wen),
      .o_rdat         (o_rdat),
      .o_err          (o_err),
      .o_awvalid      (o_awvalid),
      .i_awready      (i_awready),
      .o_awaddr       (o_awaddr),
      .o_awprot       (o_awprot),
      .o_wvalid       (o_wvalid),
      .i_wready       (i_wready),
      .o_wdata        (o_wdata),
      .o_wstrb        (o_wstrb),
      .i_bvalid       (i_bvalid),
      .o_bready       (o_bready),
      .i_bresp        (i_bresp),
      .o_arvalid      (o_arvalid),
      .i_arready      (i_arready),
      .o_araddr       (o_araddr),
      .o_arprot       (o_arprot),
      .i_rvalid       (i_rvalid),
      .o_rready       (o_rready),
      .i_rdata        (i_rdata),
      .i_rresp        (i_rresp)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [3:0]  wen;
      logic [31:0] expRdat;
      logic        expErr;
   } sbEntry_t;

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [1:0]  resp;
      logic [31:0] expRdat;
      logic        expErr;
   } vec_t;

   int          testsRun = 0;
   int          testsFailed = 0;
   bit          abortRun = 0;
   sbEntry_t    sbQ[$];
   vec_t        vecs[11];
   logic [31:0] refMem [0:255];
   logic [31:0] mem [0:255];

   // Slave configuration, set by the main sequence before each request.
   int          dAw = 0, dW = 0, dB = 0, dAr = 0, dR = 0;
   logic [1:0]  cfgBresp = 2'b00;
   logic [1:0]  cfgRresp = 2'b00;
   int          arHsCount = 0;

   // Slave internal state.
   bit          gotAw, gotW, gotAr, bHsPend, rHsPend;
   bit          awWaiting, wWaiting, arWaiting;
   int          awCnt, wCnt, bCnt, arCnt, rCnt;
   logic [31:0] capAwAddr, capWData, capArAddr;
   logic [3:0]  capWStrb;
   logic [31:0] awSaved, wSaved, arSaved;
   logic [3:0]  strbSaved;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic failNow(input string msg);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s", msg);
   endtask

   // Expected {err, rdat} for a request, from the reference memory.
   function automatic logic [32:0] modelExpect(input logic [3:0] wen, input logic [31:0] adr,
                                               input logic [1:0] bresp, input logic [1:0] rresp);
      if (wen != 4'h0) begin
         return {bresp[1], 32'h0};
      end
      return {rresp[1], (rresp[1] ? ERR_RDAT : refMem[adr[9:2]])};
   endfunction

   // Present a request to the bridge and record what it must complete with.
   task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [31:0] expRdat, input logic expErr);
      sbEntry_t e;
      e.adr = adr;
      e.wdat = wdat;
      e.wen = wen;
      e.expRdat = expRdat;
      e.expErr = expErr;
      sbQ.push_back(e);
      for (int b = 0; b < 4; b++) begin
         if (wen[b]) refMem[adr[9:2]][8*b +: 8] = wdat[8*b +: 8];
      end
      hs_ls4axim_val = 1'b1;
      i_adr = adr;
      i_wdat = wdat;
      i_axim_wen = wen;
   endtask

   // One full request: start in the next cycle, wait (bounded) for completion.
   task automatic runReq(input logic [3:0] wen, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [31:0] expRdat, input logic expErr, input bit keepVal,
                         output int lat);
      @(negedge clk);
      applyStimulus(wen, adr, wdat, expRdat, expErr);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!hs_axim4ls_rdy && lat < 200);
      if (!hs_axim4ls_rdy) begin
         failNow($sformatf("rdy timeout: no completion after %0d cycles, expected one", lat));
         abortRun = 1;
      end
      if (!keepVal) hs_ls4axim_val = 1'b0;
   endtask

   // Completion monitor: pops the scoreboard on every ready pulse.
   initial begin : monitor
      sbEntry_t e;
      logic prevRdy;
      prevRdy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && hs_axim4ls_rdy) begin
            checkVal("rdy single-cycle", 32'(prevRdy), 32'd0);
            if (sbQ.size() == 0) begin
               failNow("unexpected rdy: got a completion, expected none");
            end else begin
               e = sbQ.pop_front();
               checkVal($sformatf("rdat @%08h", e.adr), o_rdat, e.expRdat);
               checkVal($sformatf("err @%08h", e.adr), 32'(o_err), 32'(e.expErr));
            end
         end
         prevRdy = rst_n && hs_axim4ls_rdy;
      end
   end

   // Behavioural AXI4-Lite slave, acting on falling edges.
   initial begin : slave
      i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
      i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
            i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
            gotAw = 0; gotW = 0; gotAr = 0; bHsPend = 0; rHsPend = 0;
            awWaiting = 0; wWaiting = 0; arWaiting = 0;
            awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
         end else begin
            if (bHsPend) begin
               i_bvalid = 1'b0; gotAw = 0; gotW = 0; bCnt = 0;
            end
            if (gotAw && gotW && !i_bvalid) begin
               if (bCnt >= dB) begin
                  i_bvalid = 1'b1;
                  i_bresp = cfgBresp;
                  for (int b = 0; b < 4; b++) begin
                     if (capWStrb[b]) mem[capAwAddr[9:2]][8*b +: 8] = capWData[8*b +: 8];
                  end
               end else begin
                  bCnt++;
               end
            end
            bHsPend = i_bvalid && o_bready;

            if (rHsPend) begin
               i_rvalid = 1'b0; gotAr = 0; rCnt = 0;
            end
            if (gotAr && !i_rvalid) begin
               if (rCnt >= dR) begin
                  i_rvalid = 1'b1;
                  i_rresp = cfgRresp;
                  i_rdata = mem[capArAddr[9:2]];
               end else begin
                  rCnt++;
               end
            end
            rHsPend = i_rvalid && o_rready;

            if (awWaiting) begin
               checkVal("awvalid held", 32'(o_awvalid), 32'd1);
               checkVal("awaddr stable", o_awaddr, awSaved);
            end
            i_awready = o_awvalid && !gotAw && (awCnt >= dAw);
            if (o_awvalid && i_awready) begin
               gotAw = 1; awCnt = 0; capAwAddr = o_awaddr;
               if (sbQ.size() == 0) failNow("unexpected AW: got a write address, expected none");
               else begin
                  checkVal("awaddr", o_awaddr, sbQ[0].adr);
                  checkVal("awprot", 32'(o_awprot), 32'd0);
               end
            end else if (o_awvalid) begin
               awCnt++;
            end
            awWaiting = o_awvalid && !i_awready;
            awSaved = o_awaddr;

            if (wWaiting) begin
               checkVal("wvalid held", 32'(o_wvalid), 32'd1);
               checkVal("wdata stable", o_wdata, wSaved);
               checkVal("wstrb stable", 32'(o_wstrb), 32'(strbSaved));
            end
            i_wready = o_wvalid && !gotW && (wCnt >= dW);
            if (o_wvalid && i_wready) begin
               gotW = 1; wCnt = 0; capWData = o_wdata; capWStrb = o_wstrb;
               if (sbQ.size() == 0) failNow("unexpected W: got write data, expected none");
               else begin
                  checkVal("wdata", o_wdata, sbQ[0].wdat);
                  checkVal("wstrb", 32'(o_wstrb), 32'(sbQ[0].wen));
               end
            end else if (o_wvalid) begin
               wCnt++;
            end
            wWaiting = o_wvalid && !i_wready;
            wSaved = o_wdata;
            strbSaved = o_wstrb;

            if (arWaiting) begin
               checkVal("arvalid held", 32'(o_arvalid), 32'd1);
               checkVal("araddr stable", o_araddr, arSaved);
            end
            i_arready = o_arvalid && !gotAr && (arCnt >= dAr);
            if (o_arvalid && i_arready) begin
               gotAr = 1; arCnt = 0; capArAddr = o_araddr; arHsCount++;
               if (sbQ.size() == 0) failNow("unexpected AR: got a read address, expected none");
               else begin
                  checkVal("araddr", o_araddr, sbQ[0].adr);
                  checkVal("arprot", 32'(o_arprot), 32'd0);
                  checkVal("read has zero wen", 32'(sbQ[0].wen), 32'd0);
               end
            end else if (o_arvalid) begin
               arCnt++;
            end
            arWaiting = o_arvalid && !i_arready;
            arSaved = o_araddr;
         end
      end
   end

   // Bound on total simulated time.
   initial begin : watchdog
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, vector table, multi-cycle corner cases, random traffic.
   initial begin : main
      int lat;
      logic [32:0] ex;
      logic [4:0] eAw, eW, eB, eR;
      logic [3:0] wen;
      logic [31:0] adr, wdat;
      logic [17:0] hiBits;
      logic [7:0] idx;
      int r;

      vecs[0]  = '{4'h0, 32'h4000_0010, 32'h0000_0000, 2'b00, 32'h1234_5678, 1'b0};
      vecs[1]  = '{4'hF, 32'h4000_0020, 32'hCAFE_F00D, 2'b00, 32'h0000_0000, 1'b0};
      vecs[2]  = '{4'h0, 32'h4000_0020, 32'h0000_0000, 2'b00, 32'hCAFE_F00D, 1'b0};
      vecs[3]  = '{4'h3, 32'h4000_0020, 32'hAABB_CCDD, 2'b00, 32'h0000_0000, 1'b0};
      vecs[4]  = '{4'h0, 32'h4000_0020, 32'h0000_0000, 2'b00, 32'hCAFE_CCDD, 1'b0};
      vecs[5]  = '{4'h0, 32'h4000_0010, 32'h0000_0000, 2'b10, 32'h0000_0000, 1'b1};
      vecs[6]  = '{4'h8, 32'h4000_0010, 32'h9988_7766, 2'b11, 32'h0000_0000, 1'b1};
      vecs[7]  = '{4'h0, 32'h4000_0010, 32'h0000_0000, 2'b01, 32'h9934_5678, 1'b0};
      vecs[8]  = '{4'h4, 32'h4000_0020, 32'h1122_3344, 2'b01, 32'h0000_0000, 1'b0};
      vecs[9]  = '{4'h0, 32'h4000_0020, 32'h0000_0000, 2'b11, 32'h0000_0000, 1'b1};
      vecs[10] = '{4'h0, 32'h4000_0020, 32'h0000_0000, 2'b00, 32'hCA22_CCDD, 1'b0};

      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0;
         refMem[i] = 32'h0;
      end
      mem[4] = 32'h1234_5678;
      refMem[4] = 32'h1234_5678;

      rst_n = 1'b0;
      hs_ls4axim_val = 1'b0;
      i_adr = 32'h0;
      i_wdat = 32'h0;
      i_axim_wen = 4'h0;

      #3;
      checkVal("reset rdy", 32'(hs_axim4ls_rdy), 32'd0);
      checkVal("reset awvalid", 32'(o_awvalid), 32'd0);
      checkVal("reset arvalid", 32'(o_arvalid), 32'd0);
      checkVal("reset rdat", o_rdat, 32'h0);
      checkVal("reset err", 32'(o_err), 32'd0);
      checkVal("reset awaddr", o_awaddr, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Zero-wait vectors: every one must complete exactly three cycles after accept.
      for (int i = 0; i < 11; i++) begin
         dAw = 0; dW = 0; dB = 0; dAr = 0; dR = 0;
         cfgBresp = vecs[i].resp;
         cfgRresp = vecs[i].resp;
         runReq(vecs[i].wen, vecs[i].adr, vecs[i].wdat, vecs[i].expRdat, vecs[i].expErr, 1'b0, lat);
         checkVal($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
         if (abortRun) break;
      end

      // Write with W accepted at once and AW held off for two extra cycles.
      if (!abortRun) begin
         dAw = 2; dW = 0; dB = 0; cfgBresp = 2'b00;
         eAw = 5'b00111; eW = 5'b00001; eB = 5'b01000; eR = 5'b10000;
         @(negedge clk);
         applyStimulus(4'b0011, 32'h4000_0030, 32'hAABB_CCDD, 32'h0, 1'b0);
         for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkVal($sformatf("T0+%0d awvalid", k), 32'(o_awvalid), 32'(eAw[k-1]));
            checkVal($sformatf("T0+%0d wvalid", k), 32'(o_wvalid), 32'(eW[k-1]));
            checkVal($sformatf("T0+%0d bready", k), 32'(o_bready), 32'(eB[k-1]));
            checkVal($sformatf("T0+%0d rdy", k), 32'(hs_axim4ls_rdy), 32'(eR[k-1]));
            if (k == 1) checkVal("T0+1 wstrb", 32'(o_wstrb), 32'h3);
         end
         hs_ls4axim_val = 1'b0;
      end

      // Request valid held high across two back-to-back reads.
      if (!abortRun) begin
         dAw = 0; dW = 0; dB = 0; dAr = 0; dR = 0; cfgRresp = 2'b00;
         arHsCount = 0;
         ex = modelExpect(4'h0, 32'h4000_0010, 2'b00, 2'b00);
         runReq(4'h0, 32'h4000_0010, 32'h0, ex[31:0], ex[32], 1'b1, lat);
         ex = modelExpect(4'h0, 32'h4000_0020, 2'b00, 2'b00);
         runReq(4'h0, 32'h4000_0020, 32'h0, ex[31:0], ex[32], 1'b0, lat);
         checkVal("back-to-back latency", 32'(lat), 32'd3);
         repeat (6) @(negedge clk);
         checkVal("held-val AR count", 32'(arHsCount), 32'd2);
         checkVal("held-val scoreboard empty", 32'(sbQ.size()), 32'd0);
      end

      // Reset while waiting in the read-data phase, then a normal read.
      if (!abortRun) begin
         cfgRresp = 2'b01;
         ex = modelExpect(4'h0, 32'h4000_0010, 2'b00, 2'b01);
         runReq(4'h0, 32'h4000_0010, 32'h0, ex[31:0], ex[32], 1'b0, lat);
         dR = 6;
         @(negedge clk);
         applyStimulus(4'h0, 32'h4000_0020, 32'h0, 32'h0, 1'b0);
         for (int k = 0; k < 20 && !o_rready; k++) @(negedge clk);
         checkVal("rready before reset", 32'(o_rready), 32'd1);
         #2 rst_n = 1'b0;
         hs_ls4axim_val = 1'b0;
         #1;
         checkVal("async reset rready", 32'(o_rready), 32'd0);
         checkVal("async reset arvalid", 32'(o_arvalid), 32'd0);
         checkVal("async reset rdy", 32'(hs_axim4ls_rdy), 32'd0);
         checkVal("async reset rdat", o_rdat, 32'h0);
         checkVal("async reset err", 32'(o_err), 32'd0);
         checkVal("async reset araddr", o_araddr, 32'h0);
         sbQ.delete();
         @(negedge clk);
         #2 rst_n = 1'b1;
         @(negedge clk);
         checkVal("after reset arvalid", 32'(o_arvalid), 32'd0);
         checkVal("after reset rready", 32'(o_rready), 32'd0);
         dR = 0; cfgRresp = 2'b00;
         ex = modelExpect(4'h0, 32'h4000_0010, 2'b00, 2'b00);
         runReq(4'h0, 32'h4000_0010, 32'h0, ex[31:0], ex[32], 1'b0, lat);
         checkVal("after reset latency", 32'(lat), 32'd3);
      end

      // Random traffic with random channel delays and occasional error responses.
      for (int n = 0; n < 1000 && !abortRun; n++) begin
         dAw = $urandom_range(0, 7); dW = $urandom_range(0, 7); dB = $urandom_range(0, 7);
         dAr = $urandom_range(0, 7); dR = $urandom_range(0, 7);
         r = $urandom_range(0, 7);
         cfgBresp = (r == 0) ? 2'b10 : ((r == 1) ? 2'b11 : {1'b0, 1'($urandom_range(0, 1))});
         r = $urandom_range(0, 7);
         cfgRresp = (r == 0) ? 2'b10 : ((r == 1) ? 2'b11 : {1'b0, 1'($urandom_range(0, 1))});
         wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         hiBits = 18'($urandom);
         idx = 8'($urandom_range(0, 255));
         adr = {4'h4, hiBits, idx, 2'b00};
         wdat = $urandom;
         ex = modelExpect(wen, adr, cfgBresp, cfgRresp);
         runReq(wen, adr, wdat, ex[31:0], ex[32], 1'b0, lat);
      end

      repeat (4) @(negedge clk);
      checkVal("final scoreboard empty", 32'(sbQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
